// File: rtl/menu_controller.sv
// On-screen settings menu sequencer: debounces four front-panel buttons and runs the
// hidden/browse/edit state machine that drives the overlay highlight and parameter registers.
module menu_controller #(
    parameter int          NUM_ITEMS      = 5,
    parameter logic [15:0] DEB_CYCLES     = 16'd50000,
    parameter logic [9:0]  ITEM_Y0        = 10'd104,
    parameter logic [9:0]  ITEM_H         = 10'd40,
    parameter logic [9:0]  TIMEOUT_FRAMES = 10'd600,
    parameter logic [7:0]  PARAM_MAX      = 8'd255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_menu,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_ok,
    input  logic                   frame_start,
    output logic                   menu_en,
    output logic                   edit_mode,
    output logic [2:0]             sel_item,
    output logic [9:0]             hl_y1,
    output logic [9:0]             hl_y2,
    output logic [7:0]             edit_val,
    output logic                   param_wr,
    output logic [2:0]             param_addr,
    output logic [NUM_ITEMS*8-1:0] param_flat
);
    localparam logic [2:0] LAST_ITEM = 3'(NUM_ITEMS - 1);

    typedef enum logic [1:0] {S_HIDDEN, S_BROWSE, S_EDIT} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] w_btn_raw;
    logic [3:0] w_press;
    logic       w_menu, w_ok, w_up, w_down, w_any, w_timeout, w_commit;
    logic       w_menu_en, w_edit_mode;
    logic [7:0] w_cur_param;
    logic [9:0] w_hl_y1_next;
    logic [2:0] r_sel;
    logic [7:0] r_edit_val;
    logic       r_param_wr;
    logic [2:0] r_param_addr;
    logic [9:0] r_frame_cnt;
    logic [9:0] r_hl_y1;
    logic [9:0] r_hl_y2;

    assign w_btn_raw = {btn_ok, btn_down, btn_up, btn_menu};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_deb
            logic        r_sync1, r_sync2, r_level, r_level_d;
            logic [15:0] r_cnt;
            // Counter runs only while the synchronized level disagrees with the accepted one,
            // so any bounce back to the accepted level restarts the stability window.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync1   <= 1'b0;
                    r_sync2   <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_sync1   <= w_btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_level_d <= r_level;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_CYCLES - 16'd1) begin
                        r_level <= r_sync2;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
            end
            assign w_press[gi] = r_level & ~r_level_d;
        end
    endgenerate

    // Simultaneous presses: menu > ok > up > down.
    assign w_menu    = w_press[0];
    assign w_ok      = w_press[3] & ~w_press[0];
    assign w_up      = w_press[1] & ~w_press[0] & ~w_press[3];
    assign w_down    = w_press[2] & ~w_press[0] & ~w_press[3] & ~w_press[1];
    assign w_any     = |w_press;
    assign w_timeout = (r_state != S_HIDDEN) && (r_frame_cnt == TIMEOUT_FRAMES) && !w_any;
    assign w_commit  = (r_state == S_EDIT) && w_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_HIDDEN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HIDDEN: if (w_menu) w_state_next = S_BROWSE;
            S_BROWSE: begin
                if (w_menu)         w_state_next = S_HIDDEN;
                else if (w_ok)      w_state_next = S_EDIT;
                else if (w_timeout) w_state_next = S_HIDDEN;
            end
            S_EDIT: begin
                if (w_menu || w_ok) w_state_next = S_BROWSE;
                else if (w_timeout) w_state_next = S_HIDDEN;
            end
            default: w_state_next = S_HIDDEN;
        endcase
    end

    always_comb begin
        w_menu_en   = (r_state != S_HIDDEN);
        w_edit_mode = (r_state == S_EDIT);
    end

    always_comb begin
        w_cur_param = '0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (r_sel == 3'(i)) w_cur_param = param_flat[8*i +: 8];
    end

    assign w_hl_y1_next = ITEM_Y0 + 10'(r_sel) * ITEM_H;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel        <= '0;
            r_edit_val   <= '0;
            r_param_wr   <= 1'b0;
            r_param_addr <= '0;
            r_frame_cnt  <= '0;
            r_hl_y1      <= ITEM_Y0;
            r_hl_y2      <= ITEM_Y0 + ITEM_H - 10'd1;
        end else begin
            r_param_wr <= w_commit;
            if (w_commit) r_param_addr <= r_sel;
            r_hl_y1 <= w_hl_y1_next;
            r_hl_y2 <= w_hl_y1_next + ITEM_H - 10'd1;
            if (w_any || w_state_next == S_HIDDEN) r_frame_cnt <= '0;
            else if (frame_start)                  r_frame_cnt <= r_frame_cnt + 10'd1;
            case (r_state)
                S_HIDDEN: if (w_menu) r_sel <= '0;
                S_BROWSE: begin
                    if (w_ok)        r_edit_val <= w_cur_param;
                    else if (w_up)   r_sel <= (r_sel == 3'd0) ? LAST_ITEM : r_sel - 3'd1;
                    else if (w_down) r_sel <= (r_sel == LAST_ITEM) ? 3'd0 : r_sel + 3'd1;
                end
                S_EDIT: begin
                    if (w_up && r_edit_val < PARAM_MAX)        r_edit_val <= r_edit_val + 8'd1;
                    else if (w_down && r_edit_val != 8'd0)     r_edit_val <= r_edit_val - 8'd1;
                end
                default: ;
            endcase
        end
    end

    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_param
            logic [7:0] r_param;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                              r_param <= '0;
                else if (w_commit && r_sel == 3'(gi))   r_param <= r_edit_val;
            end
            assign param_flat[8*gi +: 8] = r_param;
        end
    endgenerate

    assign menu_en    = w_menu_en;
    assign edit_mode  = w_edit_mode;
    assign sel_item   = r_sel;
    assign hl_y1      = r_hl_y1;
    assign hl_y2      = r_hl_y2;
    assign edit_val   = r_edit_val;
    assign param_wr   = r_param_wr;
    assign param_addr = r_param_addr;
endmodule
